// File: rtl/edge_pipe_pkg.sv
// Shared definitions for the configurable-edge register pipeline:
// capture-edge mode codes and the valid-bit population count behind o_occ.
`timescale 1ns/1ps
package edge_pipe_pkg;

    localparam int EDGE_POS  = 0;
    localparam int EDGE_NEG  = 1;
    localparam int EDGE_DUAL = 2;

    // Widest valid vector popcount accepts; pipelines deeper than this are rejected.
    localparam int POP_W = 256;

    function automatic int popcount(input logic [POP_W-1:0] bits);
        int count;
        count = 0;
        for (int i = 0; i < POP_W; i++) begin
            count += int'(bits[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/dff_dual_edge.sv
// XOR-encoded dual-edge register: captures on both clock edges, using only plain
// single-edge flops, and with no clock in the data path.
`timescale 1ns/1ps
module dff_dual_edge #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] pe;
    logic [WIDTH-1:0] ne;

    // Each half stores d XOR the other half, so pe ^ ne equals the most recent capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pe <= '0;
        end else if (i_en) begin
            pe <= i_d ^ ne;
        end
    end

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ne <= '0;
        end else if (i_en) begin
            ne <= i_d ^ pe;
        end
    end

    assign o_q = pe ^ ne;

endmodule

// File: rtl/edge_cfg_pipe.sv
// DEPTH-stage {valid,data} register pipeline that captures on the rising edge,
// the falling edge or both, with a global enable and a live count of valid stages.
`timescale 1ns/1ps
module edge_cfg_pipe
    import edge_pipe_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3,
    parameter int EDGE_MODE = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_vld,
    input  logic [WIDTH-1:0]           i_d,
    output logic [WIDTH-1:0]           o_q,
    output logic                       o_vld,
    output logic [$clog2(DEPTH+1)-1:0] o_occ
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] stage_vld;

    if (WIDTH < 1) begin : g_bad_width
        $error("edge_cfg_pipe: WIDTH must be >= 1 (got %0d)", WIDTH);
    end
    if (DEPTH < 1 || DEPTH > POP_W) begin : g_bad_depth
        $error("edge_cfg_pipe: DEPTH must be in 1..%0d (got %0d)", POP_W, DEPTH);
    end
    if (EDGE_MODE < EDGE_POS || EDGE_MODE > EDGE_DUAL) begin : g_bad_mode
        $error("edge_cfg_pipe: EDGE_MODE must be 0, 1 or 2 (got %0d)", EDGE_MODE);
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH:0] d;
        logic [WIDTH:0] q;

        if (k == 0) begin : g_head
            assign d = {i_vld, i_d};
        end else begin : g_link
            assign d = g_stage[k-1].q;
        end

        // Invalid entries still shift, so stages hold defined data after any sequence.
        if (EDGE_MODE == EDGE_DUAL) begin : g_dual
            dff_dual_edge #(
                .WIDTH(WIDTH + 1)
            ) u_reg (
                .i_clk(i_clk),
                .i_rst(i_rst),
                .i_en (i_en),
                .i_d  (d),
                .o_q  (q)
            );
        end else if (EDGE_MODE == EDGE_NEG) begin : g_neg
            always_ff @(negedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    q <= '0;
                end else if (i_en) begin
                    q <= d;
                end
            end
        end else begin : g_pos
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    q <= '0;
                end else if (i_en) begin
                    q <= d;
                end
            end
        end

        assign stage_vld[k] = q[WIDTH];
    end

    assign o_q   = g_stage[DEPTH-1].q[WIDTH-1:0];
    assign o_vld = g_stage[DEPTH-1].q[WIDTH];
    assign o_occ = OCC_W'(popcount(POP_W'(stage_vld)));

endmodule

// File: tb/tb_edge_cfg_pipe.sv
// Drives rising, falling and dual-edge pipelines with shared stimulus and checks each
// against a shift-register reference model at every clock edge.
`timescale 1ns/1ps
module tb_edge_cfg_pipe;

    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         vld;
    logic [W-1:0] d;

    logic [W-1:0] q   [3];
    logic         qv  [3];
    logic [1:0]   occ [3];

    edge_cfg_pipe #(.WIDTH(W), .DEPTH(D), .EDGE_MODE(0)) u_pos (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_vld(vld), .i_d(d),
        .o_q(q[0]), .o_vld(qv[0]), .o_occ(occ[0])
    );
    edge_cfg_pipe #(.WIDTH(W), .DEPTH(D), .EDGE_MODE(1)) u_neg (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_vld(vld), .i_d(d),
        .o_q(q[1]), .o_vld(qv[1]), .o_occ(occ[1])
    );
    edge_cfg_pipe #(.WIDTH(W), .DEPTH(D), .EDGE_MODE(2)) u_dual (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_vld(vld), .i_d(d),
        .o_q(q[2]), .o_vld(qv[2]), .o_occ(occ[2])
    );

    always #5 clk = ~clk;

    // Reference: mdl[mode][stage] = {valid, data}; stage D-1 feeds the outputs.
    logic [W:0]   mdl [3][D];
    int           checks = 0;
    int           errors = 0;
    bit           sawEmpty [3];
    bit           sawFull  [3];
    logic [W-1:0] seenQ [$];
    logic [W-1:0] vals [4];

    function automatic int modelOcc(input int m);
        int n;
        n = 0;
        for (int s = 0; s < D; s++) n += int'(mdl[m][s][W]);
        return n;
    endfunction

    task automatic clearModel();
        for (int m = 0; m < 3; m++)
            for (int s = 0; s < D; s++) mdl[m][s] = '0;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int o;
        for (int m = 0; m < 3; m++) begin
            o = modelOcc(m);
            checkOne($sformatf("q_mode%0d", m), 32'(q[m]), 32'(mdl[m][D-1][W-1:0]));
            checkOne($sformatf("vld_mode%0d", m), 32'(qv[m]), 32'(mdl[m][D-1][W]));
            checkOne($sformatf("occ_mode%0d", m), 32'(occ[m]), 32'(o));
            if (o == 0) sawEmpty[m] = 1'b1;
            if (o == D) sawFull[m] = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [W-1:0] dd);
        en  = e;
        vld = v;
        d   = dd;
    endtask

    // Advance to the next clock edge, update the model, check 1 ns later, and return
    // at the quarter-period point where inputs may change.
    task automatic stepEdge();
        @(clk);
        if (rst) begin
            clearModel();
        end else if (en) begin
            for (int m = 0; m < 3; m++) begin
                if (m == 2 || (m == 0 && clk) || (m == 1 && !clk)) begin
                    for (int s = D - 1; s > 0; s--) mdl[m][s] = mdl[m][s-1];
                    mdl[m][0] = {vld, d};
                end
            end
        end
        #1 checkOutput();
        #1.5;
    endtask

    task automatic pulseReset();
        #0.5 rst = 1'b1;
        clearModel();
        #0.5 checkOutput();
        stepEdge();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        clearModel();
        #1 checkOutput();
        stepEdge();
        rst = 1'b0;

        $display("[TB] rising-edge single item");
        if (clk) stepEdge();
        applyStimulus(1'b1, 1'b1, 8'hA5);
        stepEdge();
        applyStimulus(1'b1, 1'b0, 8'h00);
        repeat (4) stepEdge();
        checkOne("t1_q_at_rise_n2", 32'(q[0]), 32'h0000_00A5);
        checkOne("t1_vld_at_rise_n2", 32'(qv[0]), 32'd1);
        repeat (2) stepEdge();
        checkOne("t1_vld_after_one_cycle", 32'(qv[0]), 32'd0);

        $display("[TB] falling-edge single item");
        if (!clk) stepEdge();
        applyStimulus(1'b1, 1'b1, 8'hA5);
        stepEdge();
        applyStimulus(1'b1, 1'b0, 8'h00);
        repeat (4) stepEdge();
        checkOne("t2_q_at_fall_n2", 32'(q[1]), 32'h0000_00A5);
        checkOne("t2_vld_at_fall_n2", 32'(qv[1]), 32'd1);

        $display("[TB] dual-edge stream");
        pulseReset();
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int s = 0; s < 6; s++) begin
            applyStimulus(1'b1, s < 4, (s < 4) ? vals[s] : 8'h00);
            stepEdge();
            if (s < 3) checkOne($sformatf("t3_occ_step%0d", s), 32'(occ[2]), 32'(s + 1));
            if (s >= 2) checkOne($sformatf("t3_q_step%0d", s), 32'(q[2]), 32'(vals[s-2]));
        end

        $display("[TB] enable hold");
        pulseReset();
        seenQ.delete();
        if (clk) stepEdge();
        for (int c = 0; c < 12; c++) begin
            if (c < 3)       applyStimulus(1'b1, 1'b1, 8'(c + 1));
            else if (c < 5)  applyStimulus(1'b0, 1'b1, 8'h04);
            else if (c < 8)  applyStimulus(1'b1, 1'b1, 8'(c - 1));
            else             applyStimulus(1'b1, 1'b0, 8'h00);
            stepEdge();
            if (en && qv[0]) seenQ.push_back(q[0]);
            stepEdge();
        end
        checkOne("t4_count", 32'(seenQ.size()), 32'd6);
        for (int i = 0; i < seenQ.size() && i < 6; i++)
            checkOne($sformatf("t4_item%0d", i), 32'(seenQ[i]), 32'(i + 1));

        $display("[TB] async reset from full");
        pulseReset();
        for (int s = 0; s < 6; s++) begin
            applyStimulus(1'b1, 1'b1, 8'($urandom));
            stepEdge();
        end
        for (int m = 0; m < 3; m++)
            checkOne($sformatf("t5_full_mode%0d", m), 32'(occ[m]), 32'(D));
        pulseReset();
        applyStimulus(1'b1, 1'b1, 8'h5A);
        repeat (2) stepEdge();

        $display("[TB] random");
        for (int s = 0; s < 100; s++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 8'($urandom));
            if ($urandom_range(0, 24) == 0) pulseReset();
            else stepEdge();
        end

        for (int m = 0; m < 3; m++) begin
            checkOne($sformatf("cov_empty_mode%0d", m), 32'(sawEmpty[m]), 32'd1);
            checkOne($sformatf("cov_full_mode%0d", m), 32'(sawFull[m]), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
